// File: rtl/game_tick_gen.sv
// Tick engine for game timing: one-cycle enable pulses on NUM_CH channels, each twice
// the rate of the previous one, with frame-aligned level switching, pause and restart.
module game_tick_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int BASE_HZ = 1,
  parameter int NUM_CH  = 2,
  parameter int LEVEL_W = 2,
  parameter int CNT_W   = 27,
  parameter int TCNT_W  = 16
) (
  input  logic               fpga_clock,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               pause,
  input  logic               restart,
  output logic [NUM_CH-1:0]  tick,
  output logic               game_clock,
  output logic [LEVEL_W-1:0] active_level,
  output logic [TCNT_W-1:0]  tick_cnt
);

  localparam logic [CNT_W-1:0] DIV = CNT_W'(CLK_HZ / BASE_HZ);

  // Period never drops below 2 so a pulse is always followed by a low cycle.
  function automatic logic [CNT_W-1:0] chan_period(input logic [LEVEL_W-1:0] lvl,
                                                   input int c);
    logic [CNT_W-1:0] p;
    p = DIV >> (int'(lvl) + c);
    if (p < CNT_W'(2)) p = CNT_W'(2);
    return p;
  endfunction

  logic [CNT_W-1:0] cnt_p0 [NUM_CH];
  logic [NUM_CH-1:0] wrap_p0;

  always_comb begin
    wrap_p0 = '0;
    for (int c = 0; c < NUM_CH; c++)
      wrap_p0[c] = !pause &&
                   (cnt_p0[c] == chan_period(active_level, c) - CNT_W'(1));
  end

  // Registered outputs: restart beats pause and wrap; a channel-0 wrap realigns every channel.
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) cnt_p0[c] <= '0;
      tick         <= '0;
      game_clock   <= 1'b0;
      active_level <= '0;
      tick_cnt     <= '0;
    end else if (restart) begin
      for (int c = 0; c < NUM_CH; c++) cnt_p0[c] <= '0;
      tick         <= '0;
      game_clock   <= 1'b0;
      active_level <= level;
    end else if (pause) begin
      tick <= '0;
    end else if (wrap_p0[0]) begin
      for (int c = 0; c < NUM_CH; c++) cnt_p0[c] <= '0;
      tick         <= '1;
      game_clock   <= ~game_clock;
      active_level <= level;
      tick_cnt     <= tick_cnt + TCNT_W'(1);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wrap_p0[c]) begin
          cnt_p0[c] <= '0;
          tick[c]   <= 1'b1;
        end else begin
          cnt_p0[c] <= cnt_p0[c] + CNT_W'(1);
          tick[c]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen: directed scenarios plus random stimulus, compared each cycle
// against a frame-elapsed-time reference model.
module tb_game_tick_gen;

  logic       fpga_clock = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] level = 2'd0;
  logic [1:0] tick;
  logic       game_clock;
  logic [1:0] active_level;
  logic [3:0] tick_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference state: active level, non-paused cycles elapsed in the current frame.
  int m_lvl = 0, m_e = 0, m_gc = 0, m_tc = 0;
  logic [1:0] m_tick = 2'b00;

  always #5 fpga_clock = ~fpga_clock;

  game_tick_gen #(
    .CLK_HZ(16), .BASE_HZ(1), .NUM_CH(2), .LEVEL_W(2), .CNT_W(5), .TCNT_W(4)
  ) dut (
    .fpga_clock  (fpga_clock),
    .reset       (reset),
    .level       (level),
    .pause       (pause),
    .restart     (restart),
    .tick        (tick),
    .game_clock  (game_clock),
    .active_level(active_level),
    .tick_cnt    (tick_cnt)
  );

  function automatic int per(int lvl, int c);
    int p;
    p = 16 >> (lvl + c);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(logic r, logic [1:0] l, logic p, logic rs);
    if (r) begin
      m_lvl = 0; m_e = 0; m_gc = 0; m_tc = 0; m_tick = 2'b00;
    end else if (rs) begin
      m_e = 0; m_lvl = int'(l); m_gc = 0; m_tick = 2'b00;
    end else if (p) begin
      m_tick = 2'b00;
    end else if (m_e + 1 == per(m_lvl, 0)) begin
      m_e = 0; m_lvl = int'(l); m_tick = 2'b11; m_gc = 1 - m_gc; m_tc = (m_tc + 1) % 16;
    end else begin
      for (int c = 0; c < 2; c++) m_tick[c] = ((m_e + 1) % per(m_lvl, c)) == 0;
      m_e++;
    end
  endtask

  // Drives the inputs for cycle cyc, then checks the outputs of cycle cyc+1.
  task automatic step(logic r, logic [1:0] l, logic p, logic rs);
    reset = r; level = l; pause = p; restart = rs;
    @(posedge fpga_clock);
    model_step(r, l, p, rs);
    #1;
    cyc = r ? 0 : cyc + 1;
    check("tick", 32'(tick), 32'(m_tick));
    check("game_clock", 32'(game_clock), 32'(m_gc));
    check("active_level", 32'(active_level), 32'(m_lvl));
    check("tick_cnt", 32'(tick_cnt), 32'(m_tc));
  endtask

  initial begin
    bit post;

    // Reset state
    step(1'b1, 2'd0, 1'b0, 1'b0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_tick_cnt", 32'(tick_cnt), 32'd0);

    // Level 0, free running
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b0);
      if (cyc == 8 || cyc == 24)  check("l0_tick1_only", 32'(tick), 32'd2);
      if (cyc == 12)              check("l0_quiet", 32'(tick), 32'd0);
      if (cyc == 16 || cyc == 32 || cyc == 48) check("l0_both", 32'(tick), 32'd3);
      if (cyc == 15 || cyc == 32) check("l0_gc_low", 32'(game_clock), 32'd0);
      if (cyc == 16 || cyc == 31) check("l0_gc_high", 32'(game_clock), 32'd1);
    end

    // Level 3 held through reset
    step(1'b1, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 2'd3, 1'b0, 1'b0);
      if (cyc == 15) check("l3_level_old", 32'(active_level), 32'd0);
      if (cyc == 17) check("l3_level_new", 32'(active_level), 32'd3);
      if (cyc == 18 || cyc == 20 || cyc == 22) check("l3_tick", 32'(tick), 32'd3);
      if (cyc == 19 || cyc == 21) check("l3_gap", 32'(tick), 32'd0);
    end

    // Level 0 -> 1 at cycle 5
    step(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) begin
      step(1'b0, (cyc >= 5) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      if (cyc == 16 || cyc == 24 || cyc == 32) check("lchg_both", 32'(tick), 32'd3);
      if (cyc == 20 || cyc == 28) check("lchg_tick1", 32'(tick), 32'd2);
      if (cyc == 12) check("lchg_no_early", 32'(tick), 32'd0);
    end

    // Pause over cycles 10..13
    step(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) begin
      step(1'b0, 2'd0, (cyc >= 10 && cyc <= 13), 1'b0);
      if (cyc >= 10 && cyc <= 14) check("pause_quiet", 32'(tick), 32'd0);
      if (cyc == 20) check("pause_tick_late", 32'(tick), 32'd3);
      if (cyc == 21) check("pause_tick_cnt", 32'(tick_cnt), 32'd1);
    end

    // 17 frames at level 3: tick_cnt wraps
    step(1'b1, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 2'd3, 1'b0, 1'b0);
      if (cyc == 44) check("wrap_15", 32'(tick_cnt), 32'd15);
      if (cyc == 46) check("wrap_0", 32'(tick_cnt), 32'd0);
      if (cyc == 48) check("wrap_1", 32'(tick_cnt), 32'd1);
    end

    // Restart with pause at 6, reset at 40
    step(1'b1, 2'd0, 1'b0, 1'b0);
    post = 1'b0;
    for (int i = 0; i < 52; i++) begin
      step(i == 40, 2'd0, (i == 6), (i == 6));
      if (i == 40) post = 1'b1;
      if (!post && cyc == 7)  check("rst_gc", 32'(game_clock), 32'd0);
      if (!post && cyc == 8)  check("rst_no_old_tick", 32'(tick), 32'd0);
      if (!post && cyc == 15) check("rst_tick1", 32'(tick), 32'd2);
      if (!post && cyc == 16) check("rst_no_frame", 32'(tick), 32'd0);
      if (!post && cyc == 23) check("rst_tick0", 32'(tick), 32'd3);
      if (post && cyc < 8)
        check("post_reset_zero", {26'd0, tick, game_clock, active_level, tick_cnt[0]}, 32'd0);
      if (post && cyc == 8) check("post_reset_tick1", 32'(tick), 32'd2);
    end

    // Random stimulus against the model
    step(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      int rr;
      logic [1:0] lv;
      rr = int'($urandom_range(0, 999));
      lv = 2'($urandom_range(0, 3));
      step(rr < 3, lv, (rr >= 3 && rr < 120), (rr >= 120 && rr < 130));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
